// File: rtl/pmem_wb_buffer.sv
// Purpose: single-entry write-back buffer between a cache and physical memory.
//   Evicted lines are parked in the buffer and drained to pmem when the
//   upstream side is idle. Reads that hit the parked line are served from it.
//   Reads take priority over starting a drain. A drain that has started always
//   completes before anything else happens.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   mem_read/mem_write/mem_address     upstream request (held until mem_resp)
//   mem_wdata                          upstream eviction data
//   mem_resp/mem_rdata/mem_error       upstream completion (registered)
//   pmem_read/pmem_write/pmem_address  physical memory request (registered)
//   pmem_wdata                         drain data (registered)
//   pmem_resp/pmem_error/pmem_rdata    physical memory completion
//   wb_error                           sticky: a drain finished with pmem_error
module pmem_wb_buffer (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [31:0]  mem_address,
    input  logic [255:0] mem_wdata,
    output logic         mem_resp,
    output logic [255:0] mem_rdata,
    output logic         mem_error,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic         pmem_resp,
    input  logic         pmem_error,
    input  logic [255:0] pmem_rdata,
    output logic         wb_error
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned LINE_W = 256;
    localparam int unsigned OFF_W  = 5;
    localparam int unsigned TAG_W  = ADDR_W - OFF_W;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_PMEM = 2'd1,
        S_DRAIN   = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    state_t              r_state, w_state;
    logic                r_valid, w_valid;
    logic [TAG_W-1:0]    r_tag, w_tag;
    logic [LINE_W-1:0]   r_data, w_data;
    logic                r_wb_error, w_wb_error;
    logic                r_mem_resp, w_mem_resp;
    logic [LINE_W-1:0]   r_mem_rdata, w_mem_rdata;
    logic                r_mem_error, w_mem_error;
    logic                r_pmem_read, w_pmem_read;
    logic                r_pmem_write, w_pmem_write;
    logic [ADDR_W-1:0]   r_pmem_address, w_pmem_address;
    logic [LINE_W-1:0]   r_pmem_wdata, w_pmem_wdata;

    logic [TAG_W-1:0]    w_req_tag;
    logic [OFF_W-1:0]    w_unused_offset;
    logic                w_tag_hit;
    logic                w_start_drain;

    // Byte offset within a line carries no information for line transfers.
    assign w_req_tag       = mem_address[ADDR_W-1:OFF_W];
    assign w_unused_offset = mem_address[OFF_W-1:0];
    assign w_tag_hit       = r_valid && (r_tag == w_req_tag);

    // Next-state and next-output logic; outputs are registered from these.
    always_comb begin
        w_state        = r_state;
        w_valid        = r_valid;
        w_tag          = r_tag;
        w_data         = r_data;
        w_wb_error     = r_wb_error;
        w_mem_resp     = 1'b0;
        w_mem_rdata    = '0;
        w_mem_error    = 1'b0;
        w_pmem_read    = r_pmem_read;
        w_pmem_write   = r_pmem_write;
        w_pmem_address = r_pmem_address;
        w_pmem_wdata   = r_pmem_wdata;
        w_start_drain  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (mem_read) begin
                    if (w_tag_hit) begin
                        w_state     = S_RESP;
                        w_mem_resp  = 1'b1;
                        w_mem_rdata = r_data;
                    end else begin
                        w_state        = S_RD_PMEM;
                        w_pmem_read    = 1'b1;
                        w_pmem_address = {w_req_tag, OFF_W'(0)};
                    end
                end else if (mem_write) begin
                    if (!r_valid || w_tag_hit) begin
                        w_state    = S_RESP;
                        w_mem_resp = 1'b1;
                        w_valid    = 1'b1;
                        w_tag      = w_req_tag;
                        w_data     = mem_wdata;
                    end else begin
                        w_start_drain = 1'b1;
                    end
                end else if (r_valid) begin
                    w_start_drain = 1'b1;
                end
            end
            S_RD_PMEM: begin
                if (pmem_resp) begin
                    w_state        = S_RESP;
                    w_pmem_read    = 1'b0;
                    w_pmem_address = '0;
                    w_mem_resp     = 1'b1;
                    w_mem_rdata    = pmem_rdata;
                    w_mem_error    = pmem_error;
                end
            end
            S_DRAIN: begin
                // A failed drain is not retried: the line is dropped and flagged.
                if (pmem_resp) begin
                    w_state        = S_IDLE;
                    w_pmem_write   = 1'b0;
                    w_pmem_address = '0;
                    w_pmem_wdata   = '0;
                    w_valid        = 1'b0;
                    w_wb_error     = r_wb_error | pmem_error;
                end
            end
            S_RESP: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        if (w_start_drain) begin
            w_state        = S_DRAIN;
            w_pmem_write   = 1'b1;
            w_pmem_address = {r_tag, OFF_W'(0)};
            w_pmem_wdata   = r_data;
        end
    end

    // State, buffer entry and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_valid        <= 1'b0;
            r_tag          <= '0;
            r_data         <= '0;
            r_wb_error     <= 1'b0;
            r_mem_resp     <= 1'b0;
            r_mem_rdata    <= '0;
            r_mem_error    <= 1'b0;
            r_pmem_read    <= 1'b0;
            r_pmem_write   <= 1'b0;
            r_pmem_address <= '0;
            r_pmem_wdata   <= '0;
        end else begin
            r_state        <= w_state;
            r_valid        <= w_valid;
            r_tag          <= w_tag;
            r_data         <= w_data;
            r_wb_error     <= w_wb_error;
            r_mem_resp     <= w_mem_resp;
            r_mem_rdata    <= w_mem_rdata;
            r_mem_error    <= w_mem_error;
            r_pmem_read    <= w_pmem_read;
            r_pmem_write   <= w_pmem_write;
            r_pmem_address <= w_pmem_address;
            r_pmem_wdata   <= w_pmem_wdata;
        end
    end

    assign mem_resp     = r_mem_resp;
    assign mem_rdata    = r_mem_rdata;
    assign mem_error    = r_mem_error;
    assign pmem_read    = r_pmem_read;
    assign pmem_write   = r_pmem_write;
    assign pmem_address = r_pmem_address;
    assign pmem_wdata   = r_pmem_wdata;
    assign wb_error     = r_wb_error;

endmodule

// File: tb/tb_pmem_wb_buffer.sv
// Purpose: randomized self-checking bench for pmem_wb_buffer. The bench acts
//   as both the upstream cache and the physical memory, and keeps a
//   transaction-level model of the buffered line and the sticky error flag.
module tb_pmem_wb_buffer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         mem_read, mem_write;
    logic [31:0]  mem_address;
    logic [255:0] mem_wdata;
    logic         mem_resp;
    logic [255:0] mem_rdata;
    logic         mem_error;
    logic         pmem_read, pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic         pmem_resp, pmem_error;
    logic [255:0] pmem_rdata;
    logic         wb_error;

    always #5 clk = ~clk;

    pmem_wb_buffer dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata), .mem_error(mem_error),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_resp(pmem_resp), .pmem_error(pmem_error), .pmem_rdata(pmem_rdata),
        .wb_error(wb_error)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model of the buffered line and sticky drain-error flag.
    logic         m_valid;
    logic [26:0]  m_tag;
    logic [255:0] m_data;
    logic         m_wberr;

    // Memory responder state.
    logic         in_op;
    int           lat;
    logic [31:0]  op_addr;
    logic [255:0] op_data;
    logic         hold_resp;
    int           err_mode;     // 0 random, 1 drains always fail, 2 never fail
    int           drains_in_req;
    int           reads_in_req;
    logic [31:0]  exp_rd_line;
    logic [255:0] rd_ret_data;
    logic         rd_ret_err;
    logic         prev_resp;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    // One clock: sample outputs on the falling edge and play physical memory.
    task automatic tick();
        logic e;
        @(negedge clk);
        if (prev_resp) check("resp_pulse", 256'(mem_resp), 256'(0));
        prev_resp = mem_resp;
        if (!mem_resp) check("rdata_idle", mem_rdata, 256'(0));
        check("rw_excl", 256'(pmem_read && pmem_write), 256'(0));
        if (pmem_resp) begin
            pmem_resp  = 1'b0;
            pmem_error = 1'b0;
            check("op_drop", 256'({pmem_read, pmem_write}), 256'(0));
        end else if (pmem_read || pmem_write) begin
            if (!in_op) begin
                in_op   = 1'b1;
                lat     = $urandom_range(0, 3);
                op_addr = pmem_address;
                op_data = pmem_wdata;
                if (pmem_write) begin
                    drains_in_req++;
                    check("drain_valid", 256'(m_valid), 256'(1));
                    check("drain_addr", 256'(pmem_address), 256'({m_tag, 5'b0}));
                    check("drain_data", pmem_wdata, m_data);
                end else begin
                    reads_in_req++;
                    check("rd_addr", 256'(pmem_address), 256'(exp_rd_line));
                end
            end else begin
                check("op_hold_addr", 256'(pmem_address), 256'(op_addr));
                if (pmem_write) check("op_hold_data", pmem_wdata, op_data);
            end
            if (!hold_resp) begin
                if (lat == 0) begin
                    if (pmem_write && err_mode == 1) e = 1'b1;
                    else if (err_mode == 2)          e = 1'b0;
                    else                             e = ($urandom_range(0, 7) == 0);
                    pmem_error = e;
                    pmem_rdata = rnd256();
                    pmem_resp  = 1'b1;
                    in_op      = 1'b0;
                    if (pmem_write) begin
                        m_valid = 1'b0;
                        m_wberr = m_wberr | e;
                    end else begin
                        rd_ret_data = pmem_rdata;
                        rd_ret_err  = e;
                    end
                end else begin
                    lat--;
                end
            end
        end
    endtask

    task automatic wait_resp(output int t, output logic got);
        t = 0;
        got = 1'b0;
        while (!got && t < 60) begin
            tick();
            t++;
            got = mem_resp;
        end
        check("resp_seen", 256'(got), 256'(1));
    endtask

    // Issue one upstream request (read, write, or both with read served first).
    task automatic do_req(input logic rd, input logic wr, input logic [31:0] raddr,
                          input logic [31:0] waddr, input logic [255:0] wd);
        int   t;
        int   base;
        logic got;
        logic hit;
        logic need_drain;
        drains_in_req = 0;
        reads_in_req  = 0;
        base          = mem_resp ? 2 : 1;
        mem_read      = rd;
        mem_write     = wr;
        mem_address   = rd ? raddr : waddr;
        mem_wdata     = wd;
        if (rd) begin
            exp_rd_line = {raddr[31:5], 5'b0};
            wait_resp(t, got);
            if (got) begin
                hit = m_valid && (m_tag == raddr[31:5]);
                check("rd_path", 256'(reads_in_req), 256'(hit ? 0 : 1));
                check("rd_nodrain", 256'(drains_in_req), 256'(0));
                check("rd_data", mem_rdata, hit ? m_data : rd_ret_data);
                check("rd_err", 256'(mem_error), 256'(hit ? 1'b0 : rd_ret_err));
                if (hit) check("rd_lat", 256'(t), 256'(base));
            end
            mem_read      = 1'b0;
            mem_address   = waddr;
            drains_in_req = 0;
            reads_in_req  = 0;
            base          = 2;
        end
        if (wr) begin
            need_drain = m_valid && (m_tag != waddr[31:5]);
            wait_resp(t, got);
            if (got) begin
                check("wr_drain", 256'(drains_in_req), 256'(need_drain ? 1 : 0));
                check("wr_nord", 256'(reads_in_req), 256'(0));
                if (!need_drain) check("wr_lat", 256'(t), 256'(base));
                m_valid = 1'b1;
                m_tag   = waddr[31:5];
                m_data  = wd;
            end
            mem_write = 1'b0;
        end
        check("wb_error", 256'(wb_error), 256'(m_wberr));
    endtask

    task automatic gap(input int n);
        repeat (n) tick();
        check("drained", 256'(m_valid), 256'(0));
        check("wb_error_gap", 256'(wb_error), 256'(m_wberr));
    endtask

    // Reset pulse of one clock, with outputs checked while rst_n is low.
    task automatic reset_dut();
        @(negedge clk);
        rst_n      = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        pmem_resp  = 1'b0;
        pmem_error = 1'b0;
        #1;
        check("rst_ctl", 256'({mem_resp, mem_error, pmem_read, pmem_write, wb_error}), 256'(0));
        check("rst_paddr", 256'(pmem_address), 256'(0));
        check("rst_pwdata", pmem_wdata, 256'(0));
        check("rst_rdata", mem_rdata, 256'(0));
        m_valid   = 1'b0;
        m_wberr   = 1'b0;
        in_op     = 1'b0;
        hold_resp = 1'b0;
        prev_resp = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        case ($urandom_range(0, 4))
            0: a = 32'h0000_1000;
            1: a = 32'h0000_1020;
            2: a = 32'h0000_2000;
            3: a = 32'h0000_3FE0;
            default: a = 32'hFFFF_FFE0;
        endcase
        return a | 32'($urandom_range(0, 31));
    endfunction

    initial begin
        logic [255:0] d1;
        int           kind;
        rst_n       = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
        mem_wdata   = '0;
        pmem_resp   = 1'b0;
        pmem_error  = 1'b0;
        pmem_rdata  = '0;
        m_valid     = 1'b0;
        m_tag       = '0;
        m_data      = '0;
        m_wberr     = 1'b0;
        in_op       = 1'b0;
        lat         = 0;
        op_addr     = '0;
        op_data     = '0;
        hold_resp   = 1'b0;
        err_mode    = 2;
        exp_rd_line = '0;
        rd_ret_data = '0;
        rd_ret_err  = 1'b0;
        prev_resp   = 1'b0;

        reset_dut();

        // Eviction into empty buffer, then idle drain of the same line.
        d1 = rnd256();
        do_req(1'b0, 1'b1, 32'h0, 32'h0000_1040, d1);
        gap(10);

        // Read hit on the same line served from the buffer.
        do_req(1'b0, 1'b1, 32'h0, 32'h0000_1040, d1);
        do_req(1'b1, 1'b0, 32'h0000_1050, 32'h0, '0);

        // Read and write together: read miss first, then drain, then write.
        do_req(1'b1, 1'b1, 32'h0000_2000, 32'h0000_3000, rnd256());
        gap(10);

        // Drain answered with error: sticky flag, line dropped.
        err_mode = 1;
        do_req(1'b0, 1'b1, 32'h0, 32'h0000_1040, d1);
        gap(10);
        check("wb_sticky", 256'(wb_error), 256'(1));
        err_mode = 2;
        do_req(1'b1, 1'b0, 32'h0000_1040, 32'h0, '0);
        gap(3);
        check("wb_sticky2", 256'(wb_error), 256'(1));

        // Reset in the middle of a drain.
        do_req(1'b0, 1'b1, 32'h0, 32'h0000_1040, d1);
        hold_resp = 1'b1;
        repeat (3) tick();
        check("drain_active", 256'(pmem_write), 256'(1));
        reset_dut();
        do_req(1'b1, 1'b0, 32'h0000_1040, 32'h0, '0);
        gap(3);

        // Randomized traffic.
        err_mode = 0;
        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 2);
            do_req(kind != 1, kind != 0, rnd_addr(), rnd_addr(), rnd256());
            if ($urandom_range(0, 3) == 0) gap(10);
            if ($urandom_range(0, 49) == 0) reset_dut();
        end
        gap(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
